dnn_result_reader: RTL

Run controller and result reader for the MNIST inference engine top level. It takes one inference request and pulses the engine's soft reset and then its start input. It waits for the engine's done, then walks the engine's output-select index over all class scores. It returns the argmax class and its score through a valid/ready result port, with timeout reporting.

---
 rtl/dnn_pkg.sv | 24 ++
 rtl/dnn_argmax_acc.sv | 43 ++++
 rtl/dnn_result_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dnn_pkg : shared widths, score type and reader state encoding     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package dnn_pkg;

  localparam int DATA_WIDTH  = 9;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;

  typedef logic signed [DATA_WIDTH-1:0] score_t;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_CLR   = 3'd1,
    RS_START = 3'd2,
    RS_WAIT  = 3'd3,
    RS_SCAN  = 3'd4,
    RS_RESP  = 3'd5
  } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/dnn_argmax_acc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dnn_argmax_acc : running argmax, strict greater, ties keep lowest |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dnn_argmax_acc
  import dnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sample,
  input  logic                 i_clear,
  input  logic [IDX_WIDTH-1:0] i_idx,
  input  score_t               i_score,
  output logic [IDX_WIDTH-1:0] o_best_idx,
  output score_t               o_best_score,
  output logic [IDX_WIDTH-1:0] o_next_idx,
  output score_t               o_next_score
);

  logic [IDX_WIDTH-1:0] r_best_idx;
  score_t               r_best_score;
  logic                 w_take;

  // i_clear marks the first sample of a scan, which is taken unconditionally
  assign w_take       = i_sample && (i_clear || (i_score > r_best_score));
  assign o_next_idx   = w_take ? i_idx   : r_best_idx;
  assign o_next_score = w_take ? i_score : r_best_score;
  assign o_best_idx   = r_best_idx;
  assign o_best_score = r_best_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (i_sample) begin
      r_best_idx   <= o_next_idx;
      r_best_score <= o_next_score;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dnn_result_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dnn_result_reader : runs one inference, scans scores, returns max |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dnn_result_reader
  import dnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TMO_WIDTH      = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  output logic                 o_eng_reset,
  output logic                 o_eng_start,
  input  logic                 i_eng_done,
  output logic [IDX_WIDTH-1:0] o_eng_out_idx,
  input  score_t               i_eng_out,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [IDX_WIDTH-1:0] o_res_class,
  output score_t               o_res_score,
  output logic                 o_res_error
);

  localparam logic [2:0] S_IDLE  = RS_IDLE;
  localparam logic [2:0] S_CLR   = RS_CLR;
  localparam logic [2:0] S_START = RS_START;
  localparam logic [2:0] S_WAIT  = RS_WAIT;
  localparam logic [2:0] S_SCAN  = RS_SCAN;
  localparam logic [2:0] S_RESP  = RS_RESP;

  logic [2:0]           r_state;
  logic [TMO_WIDTH-1:0] r_tmo;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] r_res_class;
  score_t               r_res_score;
  logic                 r_res_error;

  logic                 w_scan;
  logic                 w_last;
  logic                 w_tmo_hit;
  logic [IDX_WIDTH-1:0] w_best_idx;
  score_t               w_best_score;
  logic [IDX_WIDTH-1:0] w_next_idx;
  score_t               w_next_score;

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_eng_reset   = (r_state == S_CLR);
  assign o_eng_start   = (r_state == S_START);
  assign o_res_valid   = (r_state == S_RESP);
  assign o_eng_out_idx = r_idx;
  assign o_res_class   = r_res_class;
  assign o_res_score   = r_res_score;
  assign o_res_error   = r_res_error;

  assign w_scan    = (r_state == S_SCAN);
  assign w_last    = (r_idx == IDX_WIDTH'(NUM_CLASSES - 1));
  assign w_tmo_hit = (r_tmo == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

  dnn_argmax_acc u_acc (
    .clk          (clk),
    .rst          (rst),
    .i_sample     (w_scan),
    .i_clear      (r_idx == '0),
    .i_idx        (r_idx),
    .i_score      (i_eng_out),
    .o_best_idx   (w_best_idx),
    .o_best_score (w_best_score),
    .o_next_idx   (w_next_idx),
    .o_next_score (w_next_score)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_idx       <= '0;
      r_res_class <= '0;
      r_res_score <= '0;
      r_res_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) r_state <= S_CLR;
        end
        S_CLR: begin
          r_state <= S_START;
        end
        S_START: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TMO_WIDTH'(1);
          // done takes priority over a timeout landing on the same cycle
          if (i_eng_done) begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end else if (w_tmo_hit) begin
            r_res_class <= '0;
            r_res_score <= '0;
            r_res_error <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_SCAN: begin
          if (w_last) begin
            r_idx       <= '0;
            r_res_class <= w_next_idx;
            r_res_score <= w_next_score;
            r_res_error <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_idx <= r_idx + IDX_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (i_res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^{w_best_idx, w_best_score};

endmodule
`default_nettype wire
